// File: rtl/mod_step_counter.sv
// Modulo-MODULUS address/phase counter with programmable step, direction, load and wrap pulse.
// Define MOD_STEP_COUNTER_OFFSET_EN to add the phase-offset second address (offset -> count_b).
module mod_step_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] incr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
`ifdef MOD_STEP_COUNTER_OFFSET_EN
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] count_b,
`endif
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_step_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    // MOD_LO is MODULUS truncated to WIDTH bits; it is 0 when MODULUS == 2**WIDTH,
    // which still yields the right WIDTH-bit result because every result is < MODULUS.
    localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MOD_LO   = WIDTH'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] ld_clamped;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] nxt_count;
    logic             nxt_wrap;

    assign step       = ({1'b0, incr} < MOD_W) ? incr : MAX_VAL;
    assign ld_clamped = ({1'b0, ld_val} < MOD_W) ? ld_val : MAX_VAL;
    assign up_sum     = {1'b0, count} + {1'b0, step};

    always_comb begin
        nxt_count = count;
        nxt_wrap  = 1'b0;
        if (ld) begin
            nxt_count = ld_clamped;
        end else if (en) begin
            if (!dir) begin
                if (up_sum >= MOD_W) begin
                    nxt_count = count + step - MOD_LO;
                    nxt_wrap  = 1'b1;
                end else begin
                    nxt_count = count + step;
                end
            end else begin
                if (count >= step) begin
                    nxt_count = count - step;
                end else begin
                    nxt_count = count + MOD_LO - step;
                    nxt_wrap  = 1'b1;
                end
            end
        end
    end

`ifdef MOD_STEP_COUNTER_OFFSET_EN
    logic [WIDTH-1:0] off;
    logic [WIDTH:0]   b_sum;
    logic [WIDTH-1:0] nxt_count_b;

    assign off         = ({1'b0, offset} < MOD_W) ? offset : MAX_VAL;
    assign b_sum       = {1'b0, nxt_count} + {1'b0, off};
    assign nxt_count_b = (b_sum >= MOD_W) ? (nxt_count + off - MOD_LO) : (nxt_count + off);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_b <= off;
        end else begin
            count_b <= nxt_count_b;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= nxt_count;
            wrap  <= nxt_wrap;
        end
    end

endmodule

// File: doc/mod_step_counter.md
Name: mod_step_counter

Overview:
- Parametrised successor to the fixed-step 8-bit counter. Adds a programmable step, a programmable modulus, up/down direction, synchronous load and a wrap pulse.
- Serves as the address/phase generator for the sine-ROM signal generator. Frequency is set by `incr`; table length is set by MODULUS.
- Optionally provides a second, phase-offset address for dual-channel (delayed/quadrature) ROM reads.

Parameters:
- WIDTH, 8, bit width of count, incr, ld_val (and offset when enabled).
- MODULUS, 256, count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH, checked by an elaboration-time assertion.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable.
- dir  input  1  0 = count up, 1 = count down.
- incr  input  WIDTH  step size, sampled every enabled cycle.
- ld  input  1  synchronous load strobe.
- ld_val  input  WIDTH  load value.
- count  output  WIDTH  current count (registered).
- wrap  output  1  registered one-cycle pulse: the last update crossed the modulus boundary.

Behaviour:
- Reset: on a posedge with rst=1, count=0 and wrap=0. Reset mid-sequence takes effect at that edge and overrides ld/en. The cycle after rst deasserts resumes normal operation from 0.
- Priority each edge: rst > ld > en > hold.
- Load (ld=1):
  - count <= ld_val when ld_val < MODULUS; otherwise count <= MODULUS-1 (clamp).
  - wrap <= 0.
  - en, dir and incr are ignored that cycle.
- Step clamping: step = incr when incr < MODULUS; otherwise step = MODULUS-1.
- Up step (en=1, dir=0):
  - sum = count + step, computed in WIDTH+1 bits (no intermediate overflow).
  - If sum >= MODULUS: count <= sum - MODULUS, wrap <= 1.
  - Otherwise: count <= sum, wrap <= 0.
- Down step (en=1, dir=1):
  - If count >= step: count <= count - step, wrap <= 0.
  - Otherwise: count <= count + MODULUS - step, wrap <= 1.
- step = 0 with en=1: count holds, wrap <= 0.
- Hold (en=0, ld=0): count holds, wrap <= 0. wrap never stays high for two cycles unless consecutive enabled steps each wrap (e.g. step = MODULUS-1 from a nonzero count).
- Latency: count and wrap reflect the inputs sampled at the previous edge. There is no combinational path from inputs to outputs.
- dir and incr may change every cycle; each edge uses the values present at that edge.
- Invariant: count < MODULUS at all times after the first reset edge.
- Power-of-two MODULUS = 2**WIDTH must give the same results as natural WIDTH-bit wrap-around.

Optional Feature:
- Macro: MOD_STEP_COUNTER_OFFSET_EN.
- Defined:
  - Adds input `offset` [WIDTH-1:0].
  - Adds output `count_b` [WIDTH-1:0], registered: count_b = (next_count + off) mod MODULUS, where off = offset clamped to MODULUS-1 exactly like incr.
  - count_b updates on the same edge as count (same latency, no extra cycle).
  - count_b resets to off mod MODULUS. During reset, off is taken from `offset` at the reset edge.
  - count_b never drives `wrap`.
- Undefined: the `offset` and `count_b` ports do not exist, and behaviour is identical to the base block.

Test Plan:
- WIDTH=8, MODULUS=256, incr=3, dir=0, en=1 from reset:
  - count reaches 255 after 85 edges, with wrap=0 throughout.
  - The next edge gives count=2 and wrap=1.
  - The edge after that gives count=5 and wrap=0.
- MODULUS=100: ld_val=98 loaded, then incr=5 up → count=3, wrap=1. Then dir=1, incr=5 → count=98, wrap=1. Then incr=0 → count=98, wrap=0.
- Clamping, MODULUS=100: ld=1, ld_val=200 → count=99. Then incr=150 up → count=98 (99+99-100), wrap=1.
- Priority:
  - ld=1 with en=1, ld_val=7, incr=3 → count=7, wrap=0.
  - rst=1 with ld=1 → count=0.
  - rst asserted mid-count at count=42 → count=0, wrap=0 on that edge; counting resumes from 0 the edge after rst drops.
- en toggling: with incr=4, en pattern 1,0,1,1 from 0 → count 4,4,8,12. wrap is never asserted while en=0.
- With MOD_STEP_COUNTER_OFFSET_EN defined:
  - MODULUS=256, offset=64: after reset count_b=64.
  - Stepping incr=100 gives count 100,200,44; count_b 164,8,108.
  - offset changed to 128 mid-run applies from the next edge.
